// File: rtl/spi_deserializer.sv
// SPI receive path: oversamples SPI_clk/CS/DataBit with clk and assembles an
// LSB-first frame of Shift_BitCount bits into a zero-extended parallel word.
module spi_deserializer #(
    parameter int unsigned Register_Width = 32,
    parameter int unsigned Shift_BitCount = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      SPI_clk,
    input  logic                      CS,
    input  logic                      DataBit,
    output logic [Register_Width-1:0] Data_Register,
    output logic                      valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int unsigned N    = Shift_BitCount;
    localparam int unsigned CntW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } state_t;

    logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic cs_s1_q, cs_s2_q, cs_prev_q;
    logic data_s1_q, data_s2_q;

    state_t                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [N-1:0]              sr_q, sr_d;
    logic                      ovr_q, ovr_d;
    logic [Register_Width-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;
    logic                      busy_q, busy_d;

    logic sclk_rise, cs_fall, cs_rise;

    // Equal-depth synchronizers keep data aligned with the sampled clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_prev_q   <= 1'b1;
            data_s1_q   <= 1'b0;
            data_s2_q   <= 1'b0;
        end else begin
            sclk_s1_q   <= SPI_clk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            cs_s1_q     <= CS;
            cs_s2_q     <= cs_s1_q;
            cs_prev_q   <= cs_s2_q;
            data_s1_q   <= DataBit;
            data_s2_q   <= data_s1_q;
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
    assign cs_fall   = ~cs_s2_q & cs_prev_q;
    assign cs_rise   = cs_s2_q & ~cs_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            ovr_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            ovr_q   <= ovr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Frame FSM; cs_rise wins over a coincident sclk_rise, cs_fall restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ovr_d   = ovr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    sr_d    = '0;
                    ovr_d   = 1'b0;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cs_fall) begin
                    cnt_d   = '0;
                    sr_d    = '0;
                    ovr_d   = 1'b0;
                end else if (sclk_rise) begin
                    sr_d  = N'({data_s2_q, sr_q} >> 1);
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_d == CntW'(N)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (cs_rise) begin
                    if (ovr_q) begin
                        err_d = 1'b1;
                    end else begin
                        data_d  = Register_Width'(sr_q);
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (cs_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    sr_d    = '0;
                    ovr_d   = 1'b0;
                end else if (sclk_rise) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign Data_Register = data_q;
    assign valid         = valid_q;
    assign frame_err     = err_q;
    assign busy          = busy_q;

endmodule
